// File: rtl/bpu_pkg.sv
// Shared branch-prediction types: history/tag widths used by the GHR unit,
// the gshare predictor and the backend branch unit.
package bpu_pkg;

    localparam int unsigned GHR_WIDTH  = 16;
    localparam int unsigned CKPT_DEPTH = 8;
    localparam int unsigned CKPT_ID_W  = $clog2(CKPT_DEPTH);

    typedef logic [GHR_WIDTH-1:0] ghr_t;
    typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

    // Winning history action for one cycle, in priority order
    typedef enum logic [1:0] {
        GHU_IDLE,
        GHU_ADVANCE,
        GHU_REPAIR,
        GHU_FLUSH
    } ghu_action_e;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// In-order checkpoint FIFO holding pre-shift speculative history per in-flight
// branch; alloc at tail, retire at head, clear snaps both pointers together.
module ghr_ckpt_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_i,
    input  logic [W-1:0]    alloc_data_i,
    input  logic            retire_i,
    input  logic            clear_i,
    input  logic [ID_W-1:0] clear_ptr_i,
    output logic [ID_W-1:0] head_o,
    output logic [ID_W-1:0] tail_o,
    output logic [ID_W:0]   count_o,
    output logic            full_o,
    output logic [W-1:0]    head_data_o
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [ID_W-1:0] head_q, head_d;
    logic [ID_W-1:0] tail_q, tail_d;
    logic [ID_W:0]   count_q, count_d;

    // Storage is deliberately left unreset; only valid entries are ever read
    always_ff @(posedge clk) begin
        if (alloc_i) begin
            mem_q[tail_q] <= alloc_data_i;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = clear_ptr_i;
            tail_d  = clear_ptr_i;
            count_d = '0;
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + ID_W'(1);
            end
            if (retire_i) begin
                head_d = head_q + ID_W'(1);
            end
            count_d = count_q + (ID_W+1)'(alloc_i) - (ID_W+1)'(retire_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == (ID_W+1)'(DEPTH));
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/global_history_unit.sv
// Speculative/committed global-history manager feeding the gshare predictor,
// with checkpoint-based repair on mispredict and full restore on flush.
module global_history_unit #(
    parameter int unsigned GHR_WIDTH  = bpu_pkg::GHR_WIDTH,
    parameter int unsigned CKPT_DEPTH = bpu_pkg::CKPT_DEPTH,
    parameter int unsigned CKPT_ID_W  = $clog2(CKPT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 predict_valid_i,
    input  logic                 predict_taken_i,
    output logic [GHR_WIDTH-1:0] ghr_o,
    output logic [CKPT_ID_W-1:0] ckpt_id_o,
    output logic                 ckpt_full_o,
    input  logic                 resolve_valid_i,
    input  logic [CKPT_ID_W-1:0] resolve_id_i,
    input  logic                 resolve_taken_i,
    input  logic                 resolve_mispredict_i,
    input  logic                 flush_i,
    output logic [GHR_WIDTH-1:0] committed_ghr_o,
    output logic                 protocol_err_o
);

    import bpu_pkg::*;

    logic [GHR_WIDTH-1:0] spec_q, spec_d;
    logic [GHR_WIDTH-1:0] arch_q, arch_d;
    logic                 err_q, err_d;

    logic [CKPT_ID_W-1:0] head, tail, clear_ptr;
    logic [CKPT_ID_W:0]   count;
    logic                 full;
    logic [GHR_WIDTH-1:0] head_snap;

    logic        res_bad, res_ok, pred_ok, pred_drop;
    ghu_action_e act;

    always_comb begin
        // A resolve in the branch's own fetch cycle sees count == 0 and is rejected
        res_bad   = resolve_valid_i && ((resolve_id_i != head) || (count == '0));
        res_ok    = resolve_valid_i && !res_bad;
        pred_ok   = 1'b0;
        pred_drop = 1'b0;
        act       = GHU_IDLE;
        if (flush_i) begin
            act = GHU_FLUSH;
        end else if (res_ok && resolve_mispredict_i) begin
            act = GHU_REPAIR;
        end else begin
            pred_ok   = predict_valid_i && !full;
            pred_drop = predict_valid_i && full;
            if (res_ok || pred_ok) begin
                act = GHU_ADVANCE;
            end
        end
    end

    always_comb begin
        spec_d    = spec_q;
        arch_d    = arch_q;
        err_d     = err_q || res_bad || pred_drop;
        clear_ptr = tail;
        unique case (act)
            GHU_FLUSH: begin
                spec_d = arch_q;
            end
            GHU_REPAIR: begin
                arch_d    = {arch_q[GHR_WIDTH-2:0], resolve_taken_i};
                spec_d    = {head_snap[GHR_WIDTH-2:0], resolve_taken_i};
                clear_ptr = head + CKPT_ID_W'(1);
            end
            GHU_ADVANCE: begin
                if (res_ok) begin
                    arch_d = {arch_q[GHR_WIDTH-2:0], resolve_taken_i};
                end
                if (pred_ok) begin
                    spec_d = {spec_q[GHR_WIDTH-2:0], predict_taken_i};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_q <= '0;
            arch_q <= '0;
            err_q  <= 1'b0;
        end else begin
            spec_q <= spec_d;
            arch_q <= arch_d;
            err_q  <= err_d;
        end
    end

    ghr_ckpt_fifo #(
        .W     (GHR_WIDTH),
        .DEPTH (CKPT_DEPTH),
        .ID_W  (CKPT_ID_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (pred_ok),
        .alloc_data_i (spec_q),
        .retire_i     (act == GHU_ADVANCE && res_ok),
        .clear_i      (act == GHU_FLUSH || act == GHU_REPAIR),
        .clear_ptr_i  (clear_ptr),
        .head_o       (head),
        .tail_o       (tail),
        .count_o      (count),
        .full_o       (full),
        .head_data_o  (head_snap)
    );

    assign ghr_o           = spec_q;
    assign committed_ghr_o = arch_q;
    assign protocol_err_o  = err_q;
    assign ckpt_id_o       = tail;
    assign ckpt_full_o     = full;

endmodule

// File: tb/tb_global_history_unit.sv
// Scoreboard bench for global_history_unit: in-flight predicts are queued and
// retired on resolve while a reference history model tracks expected outputs.
module tb_global_history_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        predict_valid_i, predict_taken_i;
    logic [15:0] ghr_o, committed_ghr_o;
    logic [2:0]  ckpt_id_o;
    logic        ckpt_full_o;
    logic        resolve_valid_i;
    logic [2:0]  resolve_id_i;
    logic        resolve_taken_i, resolve_mispredict_i, flush_i;
    logic        protocol_err_o;

    always #5 clk = ~clk;

    global_history_unit #(
        .GHR_WIDTH  (16),
        .CKPT_DEPTH (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .predict_valid_i      (predict_valid_i),
        .predict_taken_i      (predict_taken_i),
        .ghr_o                (ghr_o),
        .ckpt_id_o            (ckpt_id_o),
        .ckpt_full_o          (ckpt_full_o),
        .resolve_valid_i      (resolve_valid_i),
        .resolve_id_i         (resolve_id_i),
        .resolve_taken_i      (resolve_taken_i),
        .resolve_mispredict_i (resolve_mispredict_i),
        .flush_i              (flush_i),
        .committed_ghr_o      (committed_ghr_o),
        .protocol_err_o       (protocol_err_o)
    );

    typedef struct {
        logic [2:0]  id;
        logic        taken;
        logic [15:0] snap;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] m_spec, m_arch;
    logic [2:0]  m_head, m_tail;
    int          m_count;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic model_reset();
        m_spec = '0; m_arch = '0; m_head = '0; m_tail = '0;
        m_count = 0; m_err = 1'b0;
        sb.delete();
    endtask

    task automatic idle();
        predict_valid_i = 0; predict_taken_i = 0; resolve_valid_i = 0;
        resolve_id_i = '0; resolve_taken_i = 0; resolve_mispredict_i = 0; flush_i = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle of stimulus; combinational outputs checked before the edge, registered after
    task automatic step(input logic pv, input logic pt, input logic rv, input logic [2:0] rid,
                        input logic rt, input logic rm, input logic fl);
        bit   bad;
        int   c0;
        ent_t e;
        @(negedge clk);
        predict_valid_i = pv; predict_taken_i = pt; resolve_valid_i = rv;
        resolve_id_i = rid; resolve_taken_i = rt; resolve_mispredict_i = rm; flush_i = fl;
        #1;
        checks++;
        if (ckpt_id_o !== m_tail) begin
            errors++; $display("FAIL ckpt_id got %0d want %0d", ckpt_id_o, m_tail);
        end
        checks++;
        if (ckpt_full_o !== (m_count == 8)) begin
            errors++; $display("FAIL ckpt_full got %0b want %0b", ckpt_full_o, (m_count == 8));
        end
        c0  = m_count;
        bad = rv && ((rid != m_head) || (m_count == 0));
        if (fl) begin
            m_spec = m_arch; m_head = m_tail; m_count = 0; sb.delete();
        end else if (rv && !bad && rm) begin
            e      = sb[0];
            m_arch = {m_arch[14:0], rt};
            m_spec = {e.snap[14:0], rt};
            m_head = m_head + 3'd1; m_tail = m_head; m_count = 0;
            sb.delete();
        end else begin
            if (rv && !bad) begin
                void'(sb.pop_front());
                m_arch = {m_arch[14:0], rt};
                m_head = m_head + 3'd1; m_count--;
            end
            if (pv) begin
                if (c0 == 8) m_err = 1'b1;
                else begin
                    e.id = m_tail; e.taken = pt; e.snap = m_spec;
                    sb.push_back(e);
                    m_spec = {m_spec[14:0], pt};
                    m_tail = m_tail + 3'd1; m_count++;
                end
            end
        end
        if (bad) m_err = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ghr_o !== m_spec) begin
            errors++; $display("FAIL ghr got %h want %h", ghr_o, m_spec);
        end
        checks++;
        if (committed_ghr_o !== m_arch) begin
            errors++; $display("FAIL committed_ghr got %h want %h", committed_ghr_o, m_arch);
        end
        checks++;
        if (protocol_err_o !== m_err) begin
            errors++; $display("FAIL protocol_err got %0b want %0b", protocol_err_o, m_err);
        end
    endtask

    task automatic predict(input logic t);
        step(1'b1, t, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve_correct();
        step(1'b0, 1'b0, 1'b1, sb[0].id, sb[0].taken, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        #1;
        checks++;
        if ({ghr_o, committed_ghr_o, ckpt_id_o, ckpt_full_o, protocol_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ghr=%h cghr=%h id=%0d full=%0b err=%0b want all 0",
                     ghr_o, committed_ghr_o, ckpt_id_o, ckpt_full_o, protocol_err_o);
        end
        checks++;
        if (dut.u_fifo.count_q !== 4'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", dut.u_fifo.count_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_predict();
        apply_reset();
        predict(1'b1); predict(1'b0); predict(1'b1);
        checks++;
        if (ghr_o !== 16'h0005) begin
            errors++; $display("FAIL predict_ghr got %h want 0005", ghr_o);
        end
        checks++;
        if (dut.u_fifo.count_q !== 4'd3) begin
            errors++; $display("FAIL predict_count got %0d want 3", dut.u_fifo.count_q);
        end
    endtask

    // Continues from the T,N,T state left by test_predict
    task automatic test_mispredict();
        resolve_correct();
        step(1'b0, 1'b0, 1'b1, sb[0].id, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ghr_o !== 16'h0003 || committed_ghr_o !== 16'h0003) begin
            errors++; $display("FAIL mispredict_ghr got %h/%h want 0003/0003", ghr_o, committed_ghr_o);
        end
        checks++;
        if (ckpt_id_o !== 3'd2 || dut.u_fifo.count_q !== 4'd0) begin
            errors++;
            $display("FAIL mispredict_ptr got id=%0d count=%0d want id=2 count=0", ckpt_id_o, dut.u_fifo.count_q);
        end
    endtask

    task automatic test_full();
        logic [15:0] g;
        apply_reset();
        for (int i = 0; i < 8; i++) predict(logic'(i % 2));
        checks++;
        if (ckpt_full_o !== 1'b1) begin
            errors++; $display("FAIL full_set got %0b want 1", ckpt_full_o);
        end
        g = ghr_o;
        predict(1'b1);
        checks++;
        if (ghr_o !== g || protocol_err_o !== 1'b1) begin
            errors++; $display("FAIL full_drop got ghr=%h err=%0b want ghr=%h err=1", ghr_o, protocol_err_o, g);
        end
        resolve_correct();
        checks++;
        if (ckpt_full_o !== 1'b0) begin
            errors++; $display("FAIL full_clear got %0b want 0", ckpt_full_o);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        predict(1'b1); predict(1'b1);
        resolve_correct(); resolve_correct();
        predict(1'b1); predict(1'b0); predict(1'b1); predict(1'b1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ghr_o !== 16'h0003 || dut.u_fifo.count_q !== 4'd0 || ckpt_id_o !== 3'd6) begin
            errors++;
            $display("FAIL flush_state got ghr=%h count=%0d id=%0d want ghr=0003 count=0 id=6",
                     ghr_o, dut.u_fifo.count_q, ckpt_id_o);
        end
    endtask

    task automatic test_protocol();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (protocol_err_o !== 1'b1 || committed_ghr_o !== 16'h0000) begin
            errors++;
            $display("FAIL empty_resolve got err=%0b cghr=%h want err=1 cghr=0000", protocol_err_o, committed_ghr_o);
        end
        apply_reset();
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (protocol_err_o !== 1'b1 || dut.u_fifo.count_q !== 4'd1) begin
            errors++;
            $display("FAIL same_cycle_resolve got err=%0b count=%0d want err=1 count=1",
                     protocol_err_o, dut.u_fifo.count_q);
        end
    endtask

    task automatic test_back_to_back();
        logic last;
        apply_reset();
        predict(1'b1);
        last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            last = logic'($urandom_range(1, 0));
            step(1'b1, last, 1'b1, sb[0].id, sb[0].taken, 1'b0, 1'b0);
        end
        checks++;
        if (ghr_o !== {committed_ghr_o[14:0], last} || protocol_err_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ghr got ghr=%h cghr=%h err=%0b want ghr=cghr<<1|%0b err=0",
                     ghr_o, committed_ghr_o, protocol_err_o, last);
        end
        checks++;
        if (ckpt_id_o !== 3'd5 || dut.u_fifo.count_q !== 4'd1) begin
            errors++;
            $display("FAIL wrap_ptr got id=%0d count=%0d want id=5 count=1", ckpt_id_o, dut.u_fifo.count_q);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 6; i++) predict(1'b1);
        resolve_correct();
        @(negedge clk);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ghr_o, committed_ghr_o, ckpt_id_o, ckpt_full_o, protocol_err_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got ghr=%h cghr=%h id=%0d full=%0b err=%0b want all 0",
                     ghr_o, committed_ghr_o, ckpt_id_o, ckpt_full_o, protocol_err_o);
        end
        checks++;
        if (dut.u_fifo.count_q !== 4'd0) begin
            errors++; $display("FAIL async_reset_count got %0d want 0", dut.u_fifo.count_q);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_predict();
        test_mispredict();
        test_full();
        test_flush();
        test_protocol();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/global_history_unit.md
# global_history_unit

Speculative global-history register (GHR) manager sitting directly upstream of the gshared base predictor; its `ghr_o` drives the predictor's `global_history_i`. It shifts predicted outcomes of conditional branches into the speculative GHR at fetch time and snapshots the pre-shift history into an in-order checkpoint FIFO. On branch resolution it retires the oldest checkpoint and maintains a committed GHR. On mispredict or pipeline flush it repairs the speculative history.

## Interface
Parameters:
- `GHR_WIDTH`, default 16: history length in bits; must be ≥ the predictor's `GLOBAL_HISTORY_LENGTH`.
- `CKPT_DEPTH`, default 8: max in-flight predicted branches; power of two.
- `CKPT_ID_W`, default $clog2(CKPT_DEPTH): checkpoint tag width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: **asynchronous, active-high** reset.
- `predict_valid_i` in 1: a conditional branch is predicted this cycle.
- `predict_taken_i` in 1: predicted direction.
- `ghr_o` out GHR_WIDTH: speculative history, registered; bit 0 is newest.
- `ckpt_id_o` out CKPT_ID_W: tag for the branch predicted this cycle (= tail pointer); carried down the pipeline.
- `ckpt_full_o` out 1: all checkpoints in use; fetch must not predict.
- `resolve_valid_i` in 1: oldest in-flight branch resolved.
- `resolve_id_i` in CKPT_ID_W: its tag.
- `resolve_taken_i` in 1: actual direction.
- `resolve_mispredict_i` in 1: direction was mispredicted.
- `flush_i` in 1: exception/ertn flush; drop all in-flight branches.
- `committed_ghr_o` out GHR_WIDTH: architectural history.
- `protocol_err_o` out 1: sticky; cleared only by `rst`.

## Operation
- State: `spec_ghr`, `arch_ghr`, checkpoint array `ckpt[CKPT_DEPTH]` (GHR_WIDTH each), `head`, `tail` (CKPT_ID_W, wrap modulo depth), `count` (CKPT_ID_W+1 bits), `err`.
- Priority per cycle: `flush_i` > mispredict resolve > normal resolve / predict (the last two may coincide).
- **Predict** (valid, not full, no flush/mispredict): `ckpt[tail] <= spec_ghr`; `spec_ghr <= {spec_ghr[W-2:0], predict_taken_i}`; `tail++`; `count++`.
- **Predict while full:** dropped; no shift; `err <= 1`.
- **Correct resolve:** `arch_ghr <= {arch_ghr[W-2:0], resolve_taken_i}`; `head++`; `count--`.
- **Mispredict resolve:** `arch_ghr` updates as above; `spec_ghr <= {ckpt[head][W-2:0], resolve_taken_i}`; `head <= tail <= head+1`; `count <= 0`; a same-cycle predict is discarded (wrong path).
- **Flush:** `spec_ghr <= arch_ghr` (pre-update value; a same-cycle resolve is ignored); `head <= tail`; `count <= 0`.
- **Protocol errors:** any of the following sets `err`, and the resolve is ignored:
  - `resolve_id_i != head`
  - resolve with `count == 0`, unless a predict occurs the same cycle with `tail == resolve_id_i`; this case is still an error, so a branch cannot be resolved in its own fetch cycle.
- Same-cycle predict + correct resolve: `count` is unchanged, and both pointers advance.

## Timing
- Reset values:
  - `ghr_o` = 0, `committed_ghr_o` = 0, `ckpt_id_o` = 0, `ckpt_full_o` = 0, `protocol_err_o` = 0.
  - `head` = `tail` = `count` = 0.
  - The checkpoint array is not reset.
- A predict in cycle N sees the pre-shift `ghr_o`; the shifted value is visible in N+1.
- `ckpt_id_o` and `ckpt_full_o` are combinational from `tail` and `count` (`full = count == CKPT_DEPTH`).
- The repaired `ghr_o` is visible in the cycle after the mispredict/flush; fetch redirect aligns with it.
- `rst` mid-operation: immediate asynchronous clear of all state; in-flight tags are void.

## Structure
- Shared package `bpu_pkg`:
  - constants `GHR_WIDTH`, `CKPT_DEPTH`
  - typedef `ghr_t` (logic [GHR_WIDTH-1:0])
  - typedef `ckpt_id_t`
  - reused by the predictor and the backend branch unit.
- One sub-module, `ghr_ckpt_fifo`, holds the checkpoint storage, the pointers, count and full. Alloc/retire/clear ports. The top level holds `spec_ghr`, `arch_ghr`, priority and error logic.

## Test plan
- **Reset, then 3 predicts** T,N,T from GHR 0 → `ghr_o` = 0x0005; `ckpt_id_o` = 0,1,2; `count` = 3.
- **Mispredict on tag 1** (flow: predicts T,N,T; resolve id0 correct T; resolve id1 mispredict, actual T) → `ghr_o` = 0x0003, `committed_ghr_o` = 0x0003, FIFO empty, next `ckpt_id_o` = 2.
- **Fill 8 checkpoints** → `ckpt_full_o` = 1; a 9th predict is dropped, `ghr_o` is unchanged and `protocol_err_o` = 1; a correct resolve the next cycle clears full.
- **Flush mid-flight** (after 2 committed T and 4 speculative predicts) → `ghr_o` = 0x0003, count 0; a same-cycle predict has no effect.
- **Wrap-around:** 20 predict/resolve pairs at one per cycle, simultaneous → tail/head wrap past 7, `ghr_o` == `committed_ghr_o` shifted by the one in-flight branch, no error.
- **Assert `rst` mid-stream** with count 5 → all outputs return to 0 without waiting for a clock edge.
